// File: rtl/lau_pkg.sv
// Shared types for the ones'-complement arithmetic blocks: adder prefix style
// and the Fletcher accumulator state encoding.
package lau_pkg;

  typedef enum logic {
    SLOW,
    FAST
  } speed_e;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } fletcher_state_e;

endpackage

// File: rtl/AddMod2Nm1.sv
// Ones'-complement adder: s = a + b mod 2^width-1, end-around carry, so the
// all-ones "negative zero" may appear in the result.
module AddMod2Nm1
  import lau_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter speed_e      speed = FAST
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] s
);

  logic [width:0] raw;

  assign raw = {1'b0, a} + {1'b0, b};

  generate
    if (speed == FAST) begin : g_fast
      // Carry-select: precompute a+b+1 so the end-around carry only drives a mux.
      logic [width-1:0] plus_one;
      assign plus_one = a + b + width'(1);
      assign s = raw[width] ? plus_one : raw[width-1:0];
    end else begin : g_slow
      assign s = raw[width-1:0] + {{(width-1){1'b0}}, raw[width]};
    end
  endgenerate

endmodule

// File: rtl/fletcher_acc_mod2nm1.sv
// Streaming Fletcher checksum accumulator (sum1/sum2 modulo 2^width-1) with a
// saturating word counter and a registered result handshake.
module fletcher_acc_mod2nm1
  import lau_pkg::*;
#(
  parameter int unsigned width     = 8,
  parameter speed_e      speed     = FAST,
  parameter int unsigned cnt_width = 16,
  parameter logic        normalize = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [width-1:0]     in_data_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [width-1:0]     out_sum1_o,
  output logic [width-1:0]     out_sum2_o,
  output logic [cnt_width-1:0] out_count_o
);

  fletcher_state_e state, state_nxt;

  logic [width-1:0]     sum1, sum2;
  logic [width-1:0]     base1, base2, s1n, s2n;
  logic [cnt_width-1:0] count, cnt_nxt;
  logic                 accept, xfer, fresh, load_out, clear;

  assign in_ready_o  = (state == DONE) ? out_ready_i : 1'b1;
  assign out_valid_o = (state == DONE);
  assign accept      = in_valid_i & in_ready_o;
  assign xfer        = out_valid_o & out_ready_i;

  // Any word accepted outside ACC opens a new frame, so the adders start from zero.
  assign fresh   = (state != ACC);
  assign base1   = fresh ? '0 : sum1;
  assign base2   = fresh ? '0 : sum2;
  assign cnt_nxt = fresh ? cnt_width'(1)
                 : ((&count) ? count : count + cnt_width'(1));

  AddMod2Nm1 #(.width(width), .speed(speed)) u_add1 (.a(base1), .b(in_data_i), .s(s1n));
  AddMod2Nm1 #(.width(width), .speed(speed)) u_add2 (.a(base2), .b(s1n),       .s(s2n));

  function automatic logic [width-1:0] norm(input logic [width-1:0] x);
    return (normalize && (&x)) ? '0 : x;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE, ACC: begin
        if (accept) begin
          state_nxt = in_last_i ? DONE : ACC;
          load_out  = in_last_i;
        end
      end
      DONE: begin
        if (xfer) begin
          if (accept) begin
            state_nxt = in_last_i ? DONE : ACC;
            load_out  = in_last_i;
          end else begin
            state_nxt = IDLE;
            clear     = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum1        <= '0;
      sum2        <= '0;
      count       <= '0;
      out_sum1_o  <= '0;
      out_sum2_o  <= '0;
      out_count_o <= '0;
    end else begin
      if (accept) begin
        sum1  <= s1n;
        sum2  <= s2n;
        count <= cnt_nxt;
      end else if (clear) begin
        sum1  <= '0;
        sum2  <= '0;
        count <= '0;
      end
      if (load_out) begin
        out_sum1_o  <= norm(s1n);
        out_sum2_o  <= norm(s2n);
        out_count_o <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fletcher_acc_mod2nm1.sv
// Self-checking bench: directed scenarios plus randomized frames against a
// modular-arithmetic reference; a second instance covers raw output and saturation.
module tb_fletcher_acc_mod2nm1;
  import lau_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, in_ready_b, out_valid_b;
  logic [7:0]  s1, s2, s1_b, s2_b;
  logic [15:0] cnt;
  logic [2:0]  cnt_b;

  int nchecks = 0;
  int nerrors = 0;
  logic acc, xfer, rdy_seen;

  typedef struct { logic [7:0] d; logic l; } word_t;
  typedef struct { logic [7:0] s1, s2, s1r, s2r; logic [15:0] c; logic [2:0] cb; } res_t;

  always #5 clk = ~clk;

  fletcher_acc_mod2nm1 #(.width(8), .speed(FAST), .cnt_width(16), .normalize(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_sum1_o(s1), .out_sum2_o(s2), .out_count_o(cnt));

  fletcher_acc_mod2nm1 #(.width(8), .speed(SLOW), .cnt_width(3), .normalize(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
    .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(out_valid_b),
    .out_ready_i(out_ready), .out_sum1_o(s1_b), .out_sum2_o(s2_b), .out_count_o(cnt_b));

  // (a+b) mod 255, except a nonzero sum that is a multiple of 255 stays all-ones.
  function automatic logic [7:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    int unsigned s, r;
    s = 32'(a) + 32'(b);
    r = s % 255;
    if (r == 0 && s != 0) r = 255;
    return 8'(r);
  endfunction

  function automatic logic [7:0] norm(input logic [7:0] x);
    return (x == 8'hFF) ? 8'h00 : x;
  endfunction

  function automatic logic [7:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r);
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    #1;
    rdy_seen = in_ready;
    acc      = v && in_ready;
    xfer     = out_valid && r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    nchecks++; if (s1 !== 8'h00 || s2 !== 8'h00) begin nerrors++; $display("FAIL reset_sums got %h/%h exp 00/00", s1, s2); end
    nchecks++; if (cnt !== 16'd0 || cnt_b !== 3'd0) begin nerrors++; $display("FAIL reset_count got %0d/%0d exp 0/0", cnt, cnt_b); end
    nchecks++; if (in_ready !== 1'b1) begin nerrors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    step(1'b1, 8'h01, 1'b0, 1'b1);
    nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL basic_early_valid got %b exp 0", out_valid); end
    step(1'b1, 8'h02, 1'b1, 1'b1);
    nchecks++; if (out_valid !== 1'b1) begin nerrors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    nchecks++; if (s1 !== 8'h03 || s2 !== 8'h04) begin nerrors++; $display("FAIL basic_sums got %h/%h exp 03/04", s1, s2); end
    nchecks++; if (cnt !== 16'd2 || cnt_b !== 3'd2) begin nerrors++; $display("FAIL basic_count got %0d/%0d exp 2/2", cnt, cnt_b); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL basic_valid_one_cycle got %b exp 0", out_valid); end
  endtask

  task automatic test_wrap();
    step(1'b1, 8'h80, 1'b0, 1'b1);
    step(1'b1, 8'h80, 1'b1, 1'b1);
    nchecks++; if (s1 !== 8'h01 || s2 !== 8'h81) begin nerrors++; $display("FAIL wrap_sums got %h/%h exp 01/81", s1, s2); end
    nchecks++; if (cnt !== 16'd2) begin nerrors++; $display("FAIL wrap_count got %0d exp 2", cnt); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_negzero();
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    nchecks++; if (s1 !== 8'h00 || s2 !== 8'h00) begin nerrors++; $display("FAIL negzero_norm got %h/%h exp 00/00", s1, s2); end
    nchecks++; if (s1_b !== 8'hFF || s2_b !== 8'hFF) begin nerrors++; $display("FAIL negzero_raw got %h/%h exp ff/ff", s1_b, s2_b); end
    nchecks++; if (cnt !== 16'd1 || cnt_b !== 3'd1) begin nerrors++; $display("FAIL negzero_count got %0d/%0d exp 1/1", cnt, cnt_b); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    step(1'b1, 8'h05, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h07, 1'b1, 1'b0);
      nchecks++; if (rdy_seen !== 1'b0) begin nerrors++; $display("FAIL bp_ready[%0d] got %b exp 0", i, rdy_seen); end
      nchecks++; if (out_valid !== 1'b1 || s1 !== 8'h05 || s2 !== 8'h05 || cnt !== 16'd1) begin
        nerrors++; $display("FAIL bp_hold[%0d] got v%b %h/%h/%0d exp v1 05/05/1", i, out_valid, s1, s2, cnt);
      end
    end
    step(1'b1, 8'h07, 1'b1, 1'b1);
    nchecks++; if (acc !== 1'b1) begin nerrors++; $display("FAIL bp_release_accept got %b exp 1", acc); end
    nchecks++; if (out_valid !== 1'b1 || s1 !== 8'h07 || s2 !== 8'h07 || cnt !== 16'd1) begin
      nerrors++; $display("FAIL bp_next got v%b %h/%h/%0d exp v1 07/07/1", out_valid, s1, s2, cnt);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'h10, 1'b0, 1'b1);
    step(1'b1, 8'h20, 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL rstmid_valid_in got %b exp 0", out_valid); end
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    nchecks++; if (out_valid !== 1'b0) begin nerrors++; $display("FAIL rstmid_valid_after got %b exp 0", out_valid); end
    step(1'b1, 8'h03, 1'b1, 1'b1);
    nchecks++; if (out_valid !== 1'b1 || s1 !== 8'h03 || s2 !== 8'h03 || cnt !== 16'd1) begin
      nerrors++; $display("FAIL rstmid_result got v%b %h/%h/%0d exp v1 03/03/1", out_valid, s1, s2, cnt);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_saturation();
    logic [7:0] e1, e2, d;
    e1 = 8'h00; e2 = 8'h00;
    for (int i = 0; i < 10; i++) begin
      d  = rand_word();
      e1 = ref_add(e1, d);
      e2 = ref_add(e2, e1);
      step(1'b1, d, (i == 9), 1'b1);
    end
    nchecks++; if (cnt !== 16'd10) begin nerrors++; $display("FAIL sat_count_wide got %0d exp 10", cnt); end
    nchecks++; if (cnt_b !== 3'd7) begin nerrors++; $display("FAIL sat_count_narrow got %0d exp 7", cnt_b); end
    nchecks++; if (s1 !== norm(e1) || s2 !== norm(e2)) begin nerrors++; $display("FAIL sat_sums got %h/%h exp %h/%h", s1, s2, norm(e1), norm(e2)); end
    nchecks++; if (s1_b !== e1 || s2_b !== e2) begin nerrors++; $display("FAIL sat_raw got %h/%h exp %h/%h", s1_b, s2_b, e1, e2); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  // Random frames with random gaps; the final frames run at full throughput.
  task automatic test_random_frames();
    word_t words[$];
    res_t  exp_q[$];
    res_t  r;
    word_t w;
    logic [7:0] e1, e2;
    logic v, rd, dense;
    int unsigned len;
    int budget;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 64);
      e1 = 8'h00; e2 = 8'h00;
      for (int unsigned i = 0; i < len; i++) begin
        w.d = rand_word();
        w.l = (i == len - 1);
        e1 = ref_add(e1, w.d);
        e2 = ref_add(e2, e1);
        words.push_back(w);
      end
      r.s1 = norm(e1); r.s2 = norm(e2); r.s1r = e1; r.s2r = e2;
      r.c  = 16'(len);
      r.cb = (len > 7) ? 3'd7 : 3'(len);
      exp_q.push_back(r);
    end
    budget = 40000;
    while (exp_q.size() > 0 && budget > 0) begin
      dense = (exp_q.size() <= 10);
      v  = (words.size() > 0) && (dense || $urandom_range(0, 3) != 0);
      rd = dense || ($urandom_range(0, 2) != 0);
      w  = (words.size() > 0) ? words[0] : '{8'h00, 1'b0};
      in_valid = v; in_data = v ? w.d : 8'($urandom); in_last = v ? w.l : 1'($urandom); out_ready = rd;
      #1;
      if (rd) begin
        nchecks++; if (in_ready !== 1'b1) begin nerrors++; $display("FAIL rand_ready got %b exp 1", in_ready); end
      end
      if (out_valid && rd) begin
        r = exp_q.pop_front();
        nchecks++;
        if (s1 !== r.s1 || s2 !== r.s2 || cnt !== r.c || s1_b !== r.s1r || s2_b !== r.s2r || cnt_b !== r.cb) begin
          nerrors++;
          $display("FAIL rand_result got %h/%h/%0d raw %h/%h/%0d exp %h/%h/%0d raw %h/%h/%0d",
                   s1, s2, cnt, s1_b, s2_b, cnt_b, r.s1, r.s2, r.c, r.s1r, r.s2r, r.cb);
        end
      end
      if (v && in_ready) void'(words.pop_front());
      @(posedge clk);
      #1;
      budget--;
    end
    nchecks++;
    if (exp_q.size() != 0) begin nerrors++; $display("FAIL rand_timeout got %0d pending exp 0", exp_q.size()); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_negzero();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/fletcher_acc_mod2nm1.md
Name: fletcher_acc_mod2nm1

Overview:
Streaming Fletcher-style checksum accumulator built on the ones'-complement adder (S = A+B mod 2^n-1, double-zero representation).
- Consumes a frame of width-bit words over a valid/ready handshake.
- Maintains running sums sum1 and sum2 modulo 2^width-1.
- Presents the final pair, plus a word count, on a registered output handshake.
- Sits directly upstream of packet framing/check logic and downstream of the data-path word source.

Parameters:
width, 8, data word and checksum width; must be >= 2.
speed, lau_pkg::FAST, prefix structure passed to both internal adders.
cnt_width, 16, width of the saturating word counter.
normalize, 1, if 1, map the all-ones ("negative zero") result to all-zeros on output; if 0, pass it through raw.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous reset, active-high.
in_valid_i  in  1  input word valid.
in_ready_o  out  1  block accepts a word this cycle.
in_data_i  in  width  data word.
in_last_i  in  1  word is the final word of the frame.
out_valid_o  out  1  result valid.
out_ready_i  in  1  consumer accepts result.
out_sum1_o  out  width  sum1 result.
out_sum2_o  out  width  sum2 result.
out_count_o  out  cnt_width  number of words in the frame, saturating at 2^cnt_width-1.

Behaviour:
- One clock. Reset is synchronous and active-high (clk_i, rst_i). rst_i has priority over every other event.
- Reset values: state=IDLE, sum1=sum2=0, count=0, out_valid_o=0, out_sum1_o=out_sum2_o=0, out_count_o=0.
- Accept event: in_valid_i & in_ready_o. Output transfer: out_valid_o & out_ready_i.
- Per accepted word d:
  - s1n = AddMod2Nm1(sum1, d); s2n = AddMod2Nm1(sum2, s1n).
  - The two adders are chained combinationally in one cycle; no extra pipeline stage.
- States:
  - IDLE: in_ready_o=1, out_valid_o=0. On accept: sum1/sum2 start from 0 (s1n = 0+d). Go to ACC, or to DONE if in_last_i.
  - ACC: in_ready_o=1. Accept updates sum1<=s1n, sum2<=s2n, count<=count+1 (saturating). Accept with in_last_i: load the output registers with s1n/s2n/count+1 and go to DONE. No accept: hold.
  - DONE: out_valid_o=1 with stable outputs until transfer; in_ready_o = out_ready_i.
    - Transfer without accept: go to IDLE and clear the accumulators.
    - Transfer with same-cycle accept (back-to-back frame): the new word starts a fresh frame from 0, count=1. Go to ACC, or reload the outputs and stay in DONE if in_last_i.
- Latency: result is valid on the cycle after the last word is accepted. Throughput is one word per cycle; no bubble between frames when out_ready_i=1.
- Single-word frame (IDLE accept with in_last_i): out_sum1_o = out_sum2_o = d (after normalization). out_count_o=1.
- Arithmetic:
  - Internal sums keep double-zero form; all-ones is legal internally.
  - Normalization (normalize=1) applies only at the output register load.
- Counter saturates; it does not wrap.
- in_data_i and in_last_i are ignored when in_valid_i=0.
- Output values are registered; no combinational path from in_* to out_*_o. in_ready_o depends combinationally on out_ready_i in DONE only.
- Reset mid-frame or mid-DONE discards the partial frame or pending result. out_valid_o is 0 in the cycle after reset.

Decomposition:
- lau_pkg gains a state typedef (IDLE, ACC, DONE) for this block.
- Sub-module: two instances of AddMod2Nm1 (width, speed) for the sum1 and sum2 updates.
- Normalization and state/counter logic stay inline.

Test Plan:
- width=8, frame {0x01,0x02(last)}, out_ready_i=1 -> one cycle after last: sum1=0x03, sum2=0x04, count=2; out_valid for 1 cycle.
- Frame {0x80,0x80(last)} -> sum1=0x01 (256 mod 255), sum2=0x81, count=2.
- Frame {0xFF(last)}: normalize=1 -> sum1=sum2=0x00; normalize=0 -> sum1=sum2=0xFF; count=1 in both cases.
- Backpressure:
  - Sequence: frame {0x05(last)}, then hold out_ready_i=0 for 5 cycles while in_valid_i=1.
  - Expected: in_ready_o=0; outputs stable at 0x05/0x05/1.
  - On out_ready_i=1, the next word {0x07(last)} is accepted in the same cycle. The next cycle shows 0x07/0x07/1.
- Reset mid-frame: accept {0x10,0x20}, assert rst_i one cycle, then frame {0x03(last)} -> result 0x03/0x03/1; out_valid_o=0 during and after reset until then.
- Randomized frames of 1..64 words against a reference model using behavioural_AddMod2Nm1, with random valid/ready gaps -> exact match on sum1, sum2 and count; saturation checked with cnt_width=3 and a 10-word frame -> count=7.
